// File: rtl/pixel_sram_arbiter.sv
// Shares one 4-bank pixel SRAM between the layer-2 conv writer (through a small write FIFO) and
// the layer-3 2x2 maxpool reader, issuing at most one SRAM action per cycle.
module pixel_sram_arbiter #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ROWS       = 16,
    parameter int unsigned COLS       = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_clear_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [15:0]       wr_row_i,
    input  logic [15:0]       wr_col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [15:0]       rd_row_i,
    input  logic [15:0]       rd_col_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_ee_o,
    output logic [DATA_W-1:0] rd_data_eo_o,
    output logic [DATA_W-1:0] rd_data_oe_o,
    output logic [DATA_W-1:0] rd_data_oo_o,
    output logic [3:0]        bank_cs_o,
    output logic [3:0]        bank_we_o,
    output logic [ADDR_W-1:0] bank_addr_o,
    output logic [DATA_W-1:0] bank_wdata_o,
    input  logic [DATA_W-1:0] bank_rdata_ee_i,
    input  logic [DATA_W-1:0] bank_rdata_eo_i,
    input  logic [DATA_W-1:0] bank_rdata_oe_i,
    input  logic [DATA_W-1:0] bank_rdata_oo_i,
    output logic              pixel_store_done_o
);

    localparam int unsigned HalfCols = COLS / 2;
    localparam int unsigned Pixels   = ROWS * COLS;
    localparam int unsigned CntW     = $clog2(Pixels);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW     = PtrW + 1;

    typedef struct packed {
        logic [1:0]        bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {GntNone, GntWr, GntRd} gnt_e;

    entry_t            fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [LvlW-1:0]   level_q;
    logic [CntW-1:0]   pix_cnt_q;
    logic              last_wr_q;
    logic              rd_valid_q;
    logic              done_q;

    gnt_e   gnt;
    entry_t head;
    entry_t wr_entry;
    logic   push, pop, urgent, wr_pend;

    assign head       = fifo_q[rptr_q];
    assign wr_ready_o = (level_q != LvlW'(FIFO_DEPTH));
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = (gnt == GntWr);
    assign wr_pend    = (level_q != '0);
    assign urgent     = (level_q >= LvlW'(FIFO_DEPTH - 1));

    // Bank and address are resolved at push time so the head drives the SRAM directly.
    assign wr_entry = '{
        bank: {wr_row_i[0], wr_col_i[0]},
        addr: ADDR_W'(32'(wr_row_i[15:1]) * HalfCols + 32'(wr_col_i[15:1])),
        data: wr_data_i
    };

    always_comb begin
        gnt = GntNone;
        if (!rst) begin
            if (urgent) begin
                gnt = GntWr;
            end else if (wr_pend && rd_req_i) begin
                gnt = last_wr_q ? GntRd : GntWr;
            end else if (wr_pend) begin
                gnt = GntWr;
            end else if (rd_req_i) begin
                gnt = GntRd;
            end
        end
    end

    always_comb begin
        rd_gnt_o     = 1'b0;
        bank_cs_o    = 4'h0;
        bank_we_o    = 4'h0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        case (gnt)
            GntWr: begin
                bank_cs_o    = 4'b0001 << head.bank;
                bank_we_o    = 4'b0001 << head.bank;
                bank_addr_o  = head.addr;
                bank_wdata_o = head.data;
            end
            GntRd: begin
                rd_gnt_o    = 1'b1;
                bank_cs_o   = 4'hF;
                bank_addr_o = ADDR_W'(32'(rd_row_i) * HalfCols + 32'(rd_col_i));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            pix_cnt_q  <= '0;
            last_wr_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= (gnt == GntRd);
            done_q     <= 1'b0;
            if (frame_clear_i) begin
                // A write granted this cycle still reaches the SRAM but is not counted.
                wptr_q    <= '0;
                rptr_q    <= '0;
                level_q   <= '0;
                pix_cnt_q <= '0;
                last_wr_q <= 1'b1;
            end else begin
                if (push) begin
                    fifo_q[wptr_q] <= wr_entry;
                    wptr_q         <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                    if (pix_cnt_q == CntW'(Pixels - 1)) begin
                        pix_cnt_q <= '0;
                        done_q    <= 1'b1;
                    end else begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                    end
                end
                level_q <= level_q + LvlW'(push) - LvlW'(pop);
                if (gnt == GntWr) begin
                    last_wr_q <= 1'b1;
                end else if (gnt == GntRd) begin
                    last_wr_q <= 1'b0;
                end
            end
        end
    end

    assign rd_valid_o         = rd_valid_q;
    assign pixel_store_done_o = done_q;
    assign rd_data_ee_o       = bank_rdata_ee_i;
    assign rd_data_eo_o       = bank_rdata_eo_i;
    assign rd_data_oe_o       = bank_rdata_oe_i;
    assign rd_data_oo_o       = bank_rdata_oo_i;

endmodule
